// File: rtl/clk_cfg_pkg.sv
// Shared types for the clock-configuration sequencer.
// Holds the FSM state enum, the target bundle and the counter width.
package clk_cfg_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      PARK,
      APPLY,
      ENGAGE
   } state_t;

   typedef struct packed {
      logic       mux0;
      logic       mux1;
      logic       mux2;
      logic [1:0] rosc;
      logic [1:0] div;
   } clk_cfg_t;

endpackage

// File: rtl/clk_cfg_seq_sync2.sv
// Generic two-flop synchronizer with async active-high reset.
// Used for the external-clock-failure level.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/clk_cfg_seq.sv
// Clock-config sequencer: park on ROSC, apply upstream selects, engage.
// Build with CLK_CFG_FAILSAFE_EN for the fallback on external-clock failure.
module clk_cfg_seq
   import clk_cfg_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_mux0,
   input  logic       req_mux1,
   input  logic       req_mux2,
   input  logic [1:0] req_rosc,
   input  logic [1:0] req_div,
   input  logic       xclk_fail,
   output logic       sel_mux0,
   output logic       sel_mux1,
   output logic       sel_mux2,
   output logic [1:0] sel_rosc,
   output logic [1:0] clk_div,
   output logic       done,
   output logic       busy,
   output logic       fail_sticky
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state;
   clk_cfg_t         cfg;
   logic [CNT_W-1:0] cnt;
   logic             fin;
   logic             trip;
   logic             accept;

`ifdef CLK_CFG_FAILSAFE_EN
   logic fail_s;

   sync2 #(.W(1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (xclk_fail),
      .q   (fail_s)
   );

   assign trip = fail_s & sel_mux0 & sel_mux1 &
                 ((state == IDLE) | (state == ENGAGE));
`else
   logic unused_xclk;

   assign unused_xclk = xclk_fail;
   assign trip        = 1'b0;
`endif

   assign accept = req_valid & req_ready & (state == IDLE);

   // Outputs follow the phase one edge after the state changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cfg         <= '0;
         cnt         <= '0;
         fin         <= 1'b0;
         sel_mux0    <= 1'b0;
         sel_mux1    <= 1'b0;
         sel_mux2    <= 1'b0;
         sel_rosc    <= 2'b00;
         clk_div     <= 2'b00;
         req_ready   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         fail_sticky <= 1'b0;
      end else begin
         fin  <= 1'b0;
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               busy      <= 1'b0;
               req_ready <= 1'b1;
               done      <= fin;
               if (accept) begin
                  cfg         <= '{req_mux0, req_mux1, req_mux2,
                                   req_rosc, req_div};
                  cnt         <= RELOAD;
                  state       <= PARK;
                  fail_sticky <= 1'b0;
               end else if (trip) begin
                  sel_mux0    <= 1'b0;
                  fail_sticky <= 1'b1;
               end
            end
            PARK: begin
               sel_mux0  <= 1'b0;
               busy      <= 1'b1;
               req_ready <= 1'b0;
               if (cnt == '0) begin
                  cnt   <= RELOAD;
                  state <= APPLY;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            APPLY: begin
               sel_mux1 <= cfg.mux1;
               sel_mux2 <= cfg.mux2;
               sel_rosc <= cfg.rosc;
               clk_div  <= cfg.div;
               if (cnt == '0) begin
                  cnt   <= RELOAD;
                  state <= ENGAGE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ENGAGE: begin
               if (trip) begin
                  sel_mux0    <= 1'b0;
                  fail_sticky <= 1'b1;
                  state       <= IDLE;
               end else begin
                  sel_mux0 <= cfg.mux0;
                  if (cnt == '0) begin
                     cnt   <= RELOAD;
                     fin   <= 1'b1;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_cfg_seq.sv
// Bench for clk_cfg_seq: S=4 and S=1 instances against a timing model.
// Fail-safe scenarios run when CLK_CFG_FAILSAFE_EN is defined.
module tb_clk_cfg_seq;
   import clk_cfg_pkg::*;

   localparam logic [10:0] RST_V = 11'b000_00_00_0100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid4 = 1'b0;
   logic       valid1 = 1'b0;
   logic       req_mux0 = 1'b0;
   logic       req_mux1 = 1'b0;
   logic       req_mux2 = 1'b0;
   logic [1:0] req_rosc = 2'b00;
   logic [1:0] req_div = 2'b00;
   logic       xclk_fail = 1'b0;

   logic       rdy4, m0_4, m1_4, m2_4, dn4, bs4, fs4;
   logic [1:0] ro4, dv4;
   logic       rdy1, m0_1, m1_1, m2_1, dn1, bs1, fs1;
   logic [1:0] ro1, dv1;
   logic [10:0] out4, out1;

   int n_cmp = 0;
   int n_bad = 0;
   clk_cfg_t cur4 = '0;
   clk_cfg_t cur1 = '0;

   assign out4 = {m0_4, m1_4, m2_4, ro4, dv4, bs4, rdy4, dn4, fs4};
   assign out1 = {m0_1, m1_1, m2_1, ro1, dv1, bs1, rdy1, dn1, fs1};

   always #5 clk = ~clk;

   clk_cfg_seq #(.SETTLE_CYCLES(4)) u_dut (
      .clk(clk), .rst(rst), .req_valid(valid4), .req_ready(rdy4),
      .req_mux0(req_mux0), .req_mux1(req_mux1), .req_mux2(req_mux2),
      .req_rosc(req_rosc), .req_div(req_div), .xclk_fail(xclk_fail),
      .sel_mux0(m0_4), .sel_mux1(m1_4), .sel_mux2(m2_4),
      .sel_rosc(ro4), .clk_div(dv4), .done(dn4), .busy(bs4),
      .fail_sticky(fs4)
   );

   clk_cfg_seq #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(rdy1),
      .req_mux0(req_mux0), .req_mux1(req_mux1), .req_mux2(req_mux2),
      .req_rosc(req_rosc), .req_div(req_div), .xclk_fail(xclk_fail),
      .sel_mux0(m0_1), .sel_mux1(m1_1), .sel_mux2(m2_1),
      .sel_rosc(ro1), .clk_div(dv1), .done(dn1), .busy(bs1),
      .fail_sticky(fs1)
   );

   // Expected outputs k edges after acceptance, from the timing table.
   function automatic logic [10:0] exp_seq(input int k, input int s,
                                           input clk_cfg_t o,
                                           input clk_cfg_t n);
      clk_cfg_t up;
      logic m0, b;
      up = (k >= 1 + s) ? n : o;
      if (k < 1) m0 = o.mux0;
      else if (k < 1 + 2 * s) m0 = 1'b0;
      else m0 = n.mux0;
      b = (k >= 1) && (k < 1 + 3 * s);
      return {m0, up.mux1, up.mux2, up.rosc, up.div,
              b, ~b, (k == 1 + 3 * s), 1'b0};
   endfunction

   function automatic clk_cfg_t rnd_cfg();
      return clk_cfg_t'(7'($urandom));
   endfunction

   // Entered and left just after a falling edge.
   task automatic run_seq(input clk_cfg_t c, input bit one, input bit hold,
                          input int f_at, input int f_len, input string nm);
      int s;
      int dn;
      clk_cfg_t o;
      logic [10:0] e, ob;
      s = one ? 1 : 4;
      o = one ? cur1 : cur4;
      {req_mux0, req_mux1, req_mux2, req_rosc, req_div} = c;
      if (one) valid1 = 1'b1;
      else valid4 = 1'b1;
      dn = 0;
      for (int k = 0; k <= 3 * s + 1; k++) begin
         @(posedge clk);
         #1;
         e  = exp_seq(k, s, o, c);
         ob = one ? out1 : out4;
         n_cmp++;
         if (ob !== e) begin
            n_bad++;
            $display("FAIL %s k=%0d got %b want %b", nm, k, ob, e);
         end
         if (ob[1]) dn++;
         @(negedge clk);
         if (hold && k < 3 * s + 1) begin
            {req_mux0, req_mux1, req_mux2, req_rosc, req_div} = rnd_cfg();
         end else begin
            valid1 = 1'b0;
            valid4 = 1'b0;
         end
         if (k == f_at) xclk_fail = 1'b1;
         if (k == f_at + f_len) xclk_fail = 1'b0;
      end
      n_cmp++;
      if (dn != 1) begin
         n_bad++;
         $display("FAIL %s done_count got %0d want 1", nm, dn);
      end
      if (one) cur1 = c;
      else cur4 = c;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (out4 !== RST_V) begin
         n_bad++;
         $display("FAIL reset4 got %b want %b", out4, RST_V);
      end
      n_cmp++;
      if (out1 !== RST_V) begin
         n_bad++;
         $display("FAIL reset1 got %b want %b", out1, RST_V);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed;
      run_seq('{1'b1, 1'b1, 1'b1, 2'b01, 2'b10}, 1'b0, 1'b0, -9, 0,
              "directed");
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++)
         run_seq(rnd_cfg(), 1'b0, 1'b0, -9, 0, "b2b");
   endtask

   task automatic test_hold_valid;
      logic [10:0] e;
      run_seq(rnd_cfg(), 1'b0, 1'b1, -9, 0, "hold");
      @(posedge clk);
      #1;
      e = {cur4, 4'b0100};
      n_cmp++;
      if (out4 !== e) begin
         n_bad++;
         $display("FAIL hold_idle got %b want %b", out4, e);
      end
      @(negedge clk);
   endtask

   task automatic test_s1;
      clk_cfg_t c;
      for (int i = 0; i < 3; i++) begin
         c = rnd_cfg();
         c.mux0 = 1'b0;
         run_seq(c, 1'b1, 1'b0, -9, 0, "s1");
      end
   endtask

   task automatic test_reset_mid;
      clk_cfg_t c;
      logic [10:0] e;
      c = rnd_cfg();
      c.mux1 = ~cur4.mux1;
      {req_mux0, req_mux1, req_mux2, req_rosc, req_div} = c;
      valid4 = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (k == 6) begin
            e = exp_seq(k, 4, cur4, c);
            n_cmp++;
            if (out4 !== e) begin
               n_bad++;
               $display("FAIL pre_rst got %b want %b", out4, e);
            end
         end
         @(negedge clk);
         valid4 = 1'b0;
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (out4 !== RST_V) begin
         n_bad++;
         $display("FAIL mid_rst4 got %b want %b", out4, RST_V);
      end
      n_cmp++;
      if (out1 !== RST_V) begin
         n_bad++;
         $display("FAIL mid_rst1 got %b want %b", out1, RST_V);
      end
      @(negedge clk);
      rst = 1'b0;
      cur4 = '0;
      cur1 = '0;
      run_seq(rnd_cfg(), 1'b0, 1'b0, -9, 0, "post_rst");
   endtask

`ifdef CLK_CFG_FAILSAFE_EN
   task automatic test_fail_idle;
      clk_cfg_t c;
      logic [10:0] e;
      c = rnd_cfg();
      c.mux0 = 1'b1;
      c.mux1 = 1'b1;
      run_seq(c, 1'b0, 1'b0, -9, 0, "fs_setup");
      xclk_fail = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         e = {(i < 3), cur4.mux1, cur4.mux2, cur4.rosc, cur4.div,
              3'b010, (i == 3)};
         n_cmp++;
         if (out4 !== e) begin
            n_bad++;
            $display("FAIL fs_idle i=%0d got %b want %b", i, out4, e);
         end
         @(negedge clk);
      end
      xclk_fail = 1'b0;
      cur4.mux0 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_fail_engage;
      clk_cfg_t c;
      logic [10:0] e;
      c = rnd_cfg();
      c.mux0 = 1'b1;
      c.mux1 = 1'b1;
      {req_mux0, req_mux1, req_mux2, req_rosc, req_div} = c;
      valid4 = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         @(posedge clk);
         #1;
         if (k <= 11) e = exp_seq(k, 4, cur4, c);
         else e = {1'b0, c.mux1, c.mux2, c.rosc, c.div,
                   (k < 13), (k >= 13), 2'b01};
         n_cmp++;
         if (out4 !== e) begin
            n_bad++;
            $display("FAIL fs_engage k=%0d got %b want %b", k, out4, e);
         end
         @(negedge clk);
         valid4 = 1'b0;
         if (k == 9) xclk_fail = 1'b1;
      end
      xclk_fail = 1'b0;
      cur4 = c;
      cur4.mux0 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_fail_apply;
      clk_cfg_t c;
      c = rnd_cfg();
      c.mux0 = 1'b1;
      c.mux1 = 1'b1;
      run_seq(c, 1'b0, 1'b0, 4, 2, "fs_apply");
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_hold_valid();
      test_s1();
`ifdef CLK_CFG_FAILSAFE_EN
      test_fail_idle();
      test_fail_engage();
      test_fail_apply();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
